// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

   localparam int         UART_DATA_W      = 8;
   localparam int         CLKS_PER_BIT_DEF = 868;
   localparam logic [7:0] CHAR_P           = 8'h50;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last count.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 serialiser: one byte per accepted strobe, LSB first, all outputs registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   i_reset_n,
   input  logic                   i_start_uart,
   input  logic [UART_DATA_W-1:0] i_uart_data,
   output logic                   o_tx,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_e            state_q, state_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   clear_s;
   logic                   tick_s;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_ni  (i_reset_n),
      .clear_i (clear_s),
      .tick_o  (tick_s)
   );

   // bit_cnt_q doubles as the stop-bit counter while in STOP
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start_uart) begin
               state_d = START;
               shift_d = i_uart_data;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (tick_s) begin
               shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d   = STOP;
                  bit_cnt_d = 3'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (tick_s) begin
               if (bit_cnt_q == STOP_LAST) begin
                  state_d   = IDLE;
                  bit_cnt_d = 3'd0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      clear_s = (state_d != state_q) || (state_q == IDLE);
      busy_d  = (state_d != IDLE);

      // Line level is derived from next state so the pin changes on the same edge as the FSM
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= 3'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes and checks frames.
module tb_uart_tx;
   import uart_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start, start2;
   logic [7:0] data, data2;
   logic       tx, busy, done;
   logic       tx2, busy2, done2;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;
   logic [7:0] exp_q[$];

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
      .clk(clk), .i_reset_n(rst_n), .i_start_uart(start), .i_uart_data(data),
      .o_tx(tx), .o_busy(busy), .o_done(done)
   );

   uart_tx #(.CLKS_PER_BIT(868), .STOP_BITS(2)) dut2 (
      .clk(clk), .i_reset_n(rst_n), .i_start_uart(start2), .i_uart_data(data2),
      .o_tx(tx2), .o_busy(busy2), .o_done(done2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line monitor: capture o_tx while busy, check the whole frame on o_done
   int         cyc_n = 0;
   logic       line_r [0:79];
   logic [7:0] mon_e, mon_got;
   int         mon_mis, mon_idx;
   logic       mon_bit;

   always @(negedge clk) begin
      if (!rst_n) begin
         cyc_n = 0;
      end else begin
         if (busy === 1'b1) begin
            if (cyc_n < 80) line_r[cyc_n] = tx;
            cyc_n++;
         end
         if (done === 1'b1) begin
            n_done++;
            chk("done_cycle_tx", tx, 1);
            chk("done_cycle_busy", busy, 0);
            chk("frame_len", cyc_n, 40);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got a frame, expected none");
            end else begin
               mon_e   = exp_q.pop_front();
               mon_mis = 0;
               mon_got = 8'h00;
               for (int c = 0; c < 40; c++) begin
                  mon_idx = c / 4;
                  mon_bit = (mon_idx == 0) ? 1'b0 : (mon_idx == 9) ? 1'b1 : mon_e[mon_idx-1];
                  if (line_r[c] !== mon_bit) mon_mis++;
               end
               for (int b = 0; b < 8; b++) mon_got[b] = line_r[(b + 1) * 4 + 2];
               chk("line_bits_wrong", mon_mis, 0);
               chk("decoded_byte", mon_got, mon_e);
            end
            cyc_n = 0;
         end
      end
   end

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      start = 1'b1;
      data  = d;
      exp_q.push_back(d);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no o_done within %0d cycles, expected one", name, budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, saved_done, len, hi_tail, k;
      start = 1'b0; data = 8'h00; start2 = 1'b0; data2 = 8'h00;

      // asynchronous reset, checked before any clock edge
      #3 rst_n = 1'b0;
      #1;
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_tx2", tx2, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // single byte, first-cycle latency
      send(CHAR_P);
      chk("start_latency_busy", busy, 1);
      chk("start_latency_tx", tx, 0);
      wait_done("single", 60);
      @(negedge clk);

      // request while busy is dropped
      send(8'h50);
      repeat (10) @(negedge clk);
      start = 1'b1; data = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_req", 60);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      chk("ignored_req_busy_cycles", cnt, 0);

      // back-to-back: strobe in the o_done cycle
      send(8'h50);
      wait_done("b2b_first", 60);
      start = 1'b1; data = 8'h55;
      exp_q.push_back(8'h55);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_tx", tx, 0);
      wait_done("b2b_second", 60);
      @(negedge clk);

      // strobe held high: continuous frames
      start = 1'b1; data = 8'h3C;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h3C);
      wait_done("held_first", 60);
      @(negedge clk);
      chk("held_restart_busy", busy, 1);
      start = 1'b0;
      wait_done("held_second", 60);
      @(negedge clk);
      chk("held_stop_busy", busy, 0);

      // mid-frame reset during DATA bit 3
      send(8'h50);
      repeat (17) @(negedge clk);
      chk("pre_reset_tx", tx, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_tx", tx, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      exp_q.delete();
      saved_done = n_done;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("midreset_no_done", n_done, saved_done);
      chk("midreset_idle_busy", busy, 0);
      send(8'hA5);
      wait_done("after_reset", 60);
      @(negedge clk);

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("done_count", n_done, 7);

      // 8N2 at full baud divisor
      @(negedge clk);
      start2 = 1'b1; data2 = 8'h00;
      @(negedge clk);
      start2 = 1'b0;
      chk("n2_start_tx", tx2, 0);
      len = 0; hi_tail = 0; k = 0;
      while (busy2 === 1'b1 && k < 12000) begin
         len++;
         if (tx2 === 1'b1) hi_tail++;
         else hi_tail = 0;
         @(negedge clk);
         k++;
      end
      chk("n2_frame_len", len, 9548);
      chk("n2_stop_high", hi_tail, 1736);
      chk("n2_done", done2, 1);
      @(negedge clk);
      chk("n2_done_single", done2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
